// File: rtl/des_uart_pkg.sv
// des_uart_pkg
// Shared definitions for the DES result UART readout path:
//   state_t          - transmitter / sequencer state encoding
//   ASCII_*          - character constants (CR, LF, '0', 'A')
//   nibble_to_ascii  - 4-bit value to uppercase ASCII hex digit
package des_uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_BIT = 3'd1,
        DATA_BITS = 3'd2,
        STOP_BIT  = 3'd3,
        NEXT_CHAR = 3'd4
    } state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10)
            return ASCII_0 + {4'h0, nib};
        else
            return ASCII_A + {4'h0, nib} - 8'd10;
    endfunction

endpackage

// File: rtl/des_result_uart_tx_byte.sv
// uart_tx_byte
// 8N1 byte serializer. Owns the baud counter and bit counter.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   load        - take tx_byte this cycle (only honoured while ready = 1)
//   tx_byte     - byte to send, LSB first
//   ready       - 1 when idle, or in the last cycle of a stop bit; a load in
//                 that last cycle chains the next start bit with no gap
//   txd         - serial line, idle high
module uart_tx_byte
    import des_uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] tx_byte,
    output logic       ready,
    output logic       txd
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);

    state_t          state_reg;
    logic [CW-1:0]   baud_reg;
    logic [2:0]      bit_reg;
    logic [7:0]      shift_reg;
    logic            txd_reg;

    logic bit_end;
    assign bit_end = (baud_reg == DIV_M1);
    assign ready   = (state_reg == IDLE) || ((state_reg == STOP_BIT) && bit_end);
    assign txd     = txd_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            baud_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            txd_reg   <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    baud_reg <= '0;
                    bit_reg  <= '0;
                    if (load) begin
                        shift_reg <= tx_byte;
                        txd_reg   <= 1'b0;
                        state_reg <= START_BIT;
                    end
                end
                START_BIT: begin
                    if (bit_end) begin
                        baud_reg  <= '0;
                        txd_reg   <= shift_reg[0];
                        state_reg <= DATA_BITS;
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end
                DATA_BITS: begin
                    if (bit_end) begin
                        baud_reg <= '0;
                        if (bit_reg == 3'd7) begin
                            bit_reg   <= '0;
                            txd_reg   <= 1'b1;
                            state_reg <= STOP_BIT;
                        end else begin
                            bit_reg   <= bit_reg + 3'd1;
                            // shift_reg[0] is on the line; bring the next bit up
                            txd_reg   <= shift_reg[1];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                        end
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end
                STOP_BIT: begin
                    if (bit_end) begin
                        baud_reg <= '0;
                        if (load) begin
                            // next character starts straight after this stop bit
                            shift_reg <= tx_byte;
                            txd_reg   <= 1'b0;
                            state_reg <= START_BIT;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    txd_reg   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/des_result_uart_tx.sv
// des_result_uart_tx
// Captures a 64-bit DES result on start and sends it as 16 uppercase ASCII
// hex characters, most-significant nibble first, over an 8N1 UART line.
// Optional feature macro: DES_TX_CRLF_EN appends CR LF (18 characters).
// Ports:
//   clk      - system clock (CLOCK_50 at board level)
//   rst_n    - asynchronous active-low reset
//   start    - one-cycle transmit request, accepted only when idle
//   data_in  - 64-bit result, sampled on acceptance
//   busy     - high from the cycle after acceptance to the end of the last stop bit
//   done     - one-cycle pulse after the last stop bit
//   txd      - UART line, idle high
module des_result_uart_tx
    import des_uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] data_in,
    output logic        busy,
    output logic        done,
    output logic        txd
);

`ifdef DES_TX_CRLF_EN
    localparam logic [4:0] LAST_IDX = 5'd17;
`else
    localparam logic [4:0] LAST_IDX = 5'd15;
`endif

    state_t       state_reg;
    logic [63:0]  shadow_reg;
    logic [4:0]   idx_reg;
    logic         busy_reg;
    logic         done_reg;

    logic         ser_ready;
    logic         load;
    logic [4:0]   sel_idx;
    logic [3:0]   nib;
    logic [7:0]   tx_byte;

    assign busy = busy_reg;
    assign done = done_reg;

    // NEXT_CHAR: the first character is handed over one cycle after acceptance.
    // START_BIT here means "a character is on the line"; when the serializer
    // reports ready the next character is handed over in that same cycle.
    always_comb begin
        load    = 1'b0;
        sel_idx = idx_reg;
        if (state_reg == NEXT_CHAR) begin
            load = 1'b1;
        end else if ((state_reg == START_BIT) && ser_ready && (idx_reg != LAST_IDX)) begin
            load    = 1'b1;
            sel_idx = idx_reg + 5'd1;
        end
        nib     = 4'(shadow_reg >> (7'd60 - {sel_idx, 2'b00}));
        tx_byte = nibble_to_ascii(nib);
`ifdef DES_TX_CRLF_EN
        if (sel_idx == 5'd16)
            tx_byte = ASCII_CR;
        else if (sel_idx == 5'd17)
            tx_byte = ASCII_LF;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            shadow_reg <= '0;
            idx_reg    <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // no restart in the done cycle itself
                    if (start && !busy_reg && !done_reg) begin
                        shadow_reg <= data_in;
                        idx_reg    <= '0;
                        busy_reg   <= 1'b1;
                        state_reg  <= NEXT_CHAR;
                    end
                end
                NEXT_CHAR: begin
                    state_reg <= START_BIT;
                end
                START_BIT: begin
                    if (ser_ready) begin
                        if (idx_reg == LAST_IDX) begin
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end else begin
                            idx_reg <= idx_reg + 5'd1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    uart_tx_byte #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .tx_byte (tx_byte),
        .ready   (ser_ready),
        .txd     (txd)
    );

endmodule
